// File: rtl/vga_sync.sv
// VGA timing generator: divides the system clock down to a pixel rate and
// produces pixel coordinates, sync pulses, and visible-area and frame markers.
module vga_sync #(
  parameter int DIV       = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       f_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DW-1:0] div;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic          h_wrap;
  logic          v_wrap;

  function automatic logic in_range(input logic [9:0] val,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  // Pixel-rate divider: the tick is suppressed while reset is held so that
  // DIV=1 still reports no tick during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign p_tick = !rst && (div == DIV_LAST);
  assign h_wrap = (pixel_x == H_LAST);
  assign v_wrap = (pixel_y == V_LAST);
  assign f_tick = p_tick && h_wrap && v_wrap;

  always_comb begin
    h_next = pixel_x;
    v_next = pixel_y;
    if (p_tick) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : pixel_y + 10'd1;
      end else begin
        h_next = pixel_x + 10'd1;
      end
    end
  end

  // Decoding from the next-state counters keeps sync/blank aligned with the
  // coordinate outputs on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      pixel_x  <= h_next;
      pixel_y  <= v_next;
      hsync    <= !in_range(h_next, HS_FIRST, HS_LAST);
      vsync    <= !in_range(v_next, VS_FIRST, VS_LAST);
      video_on <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync with a reduced raster (15x12 pixels, 4 clks per pixel):
// driver pushes expected outputs per cycle, monitor pops and compares.
module tb_vga_sync;

  localparam int DIV_T = 4;
  localparam int HD = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VD = 6, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HD + HFP + HS + HBP;
  localparam int VT = VD + VFP + VS + VBP;
  localparam int FRAME_CLKS = 720;

  typedef struct {
    int         t;
    logic       r;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       ft;
  } exp_t;

  // Hand-computed points: t = non-reset edges since release; value packs
  // {pixel_x, pixel_y, hsync, vsync, video_on, p_tick, f_tick}.
  localparam int NH = 18;
  localparam int HAND_T[NH] = '{1, 3, 4, 7, 11, 12, 28, 32, 40, 48, 52, 60,
                                464, 480, 596, 600, 719, 720};
  localparam logic [24:0] HAND_V[NH] = '{
    {10'd0,  10'd0,  5'b11100}, {10'd0,  10'd0,  5'b11110},
    {10'd1,  10'd0,  5'b11100}, {10'd1,  10'd0,  5'b11110},
    {10'd2,  10'd0,  5'b11110}, {10'd3,  10'd0,  5'b11100},
    {10'd7,  10'd0,  5'b11100}, {10'd8,  10'd0,  5'b11000},
    {10'd10, 10'd0,  5'b01000}, {10'd12, 10'd0,  5'b01000},
    {10'd13, 10'd0,  5'b11000}, {10'd0,  10'd1,  5'b11100},
    {10'd11, 10'd7,  5'b01000}, {10'd0,  10'd8,  5'b10000},
    {10'd14, 10'd9,  5'b10000}, {10'd0,  10'd10, 5'b11000},
    {10'd14, 10'd11, 5'b11011}, {10'd0,  10'd0,  5'b11100}};

  logic       clk;
  logic       rst;
  logic       hsync, vsync, video_on, p_tick, f_tick;
  logic [9:0] pixel_x, pixel_y;

  int   tests = 0;
  int   fails = 0;
  int   t_cnt = 0;
  exp_t sb[$];

  vga_sync #(
    .DIV(DIV_T), .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y), .f_tick(f_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form reference: after t edges out of reset, t/DIV pixels elapsed.
  function automatic exp_t model(input int t, input logic r);
    exp_t e;
    int   idx;
    e.t  = t;
    e.r  = r;
    if (r) begin
      e.x = '0; e.y = '0; e.hs = 1'b1; e.vs = 1'b1;
      e.vo = 1'b0; e.pt = 1'b0; e.ft = 1'b0;
    end else begin
      idx  = t / DIV_T;
      e.x  = 10'(idx % HT);
      e.y  = 10'((idx / HT) % VT);
      e.pt = ((t % DIV_T) == DIV_T - 1);
      e.hs = !((int'(e.x) >= HD + HFP) && (int'(e.x) <= HD + HFP + HS - 1));
      e.vs = !((int'(e.y) >= VD + VFP) && (int'(e.y) <= VD + VFP + VS - 1));
      e.vo = (int'(e.x) < HD) && (int'(e.y) < VD);
      e.ft = e.pt && (int'(e.x) == HT - 1) && (int'(e.y) == VT - 1);
    end
    return e;
  endfunction

  task automatic step(input logic r);
    rst = r;
    if (r) t_cnt = 0;
    else   t_cnt = t_cnt + 1;
    sb.push_back(model(t_cnt, r));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3)    step(1'b1);
    repeat (1500) step(1'b0);
    repeat (2)    step(1'b1);
    repeat (202)  step(1'b0);
    step(1'b1);
    repeat (800)  step(1'b0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: one sample per cycle, 1 time unit after the active edge.
  initial begin
    exp_t        e;
    logic [24:0] got, want;
    longint      cyc = 0;
    longint      last_f = 0;
    bit          have_f = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      got = {pixel_x, pixel_y, hsync, vsync, video_on, p_tick, f_tick};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: DUT output %h with no expected entry", got);
      end else begin
        e    = sb.pop_front();
        want = {e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.ft};
        if (got !== want) begin
          fails++;
          $display("FAIL model t=%0d rst=%0b: got x=%0d y=%0d hs%0b vs%0b vo%0b pt%0b ft%0b, required x=%0d y=%0d hs%0b vs%0b vo%0b pt%0b ft%0b",
                   e.t, e.r, pixel_x, pixel_y, hsync, vsync, video_on, p_tick, f_tick,
                   e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.ft);
        end
        if (!e.r) begin
          for (int i = 0; i < NH; i++) begin
            if (HAND_T[i] == e.t) begin
              tests++;
              if (got !== HAND_V[i]) begin
                fails++;
                $display("FAIL hand t=%0d: got %h, required %h", e.t, got, HAND_V[i]);
              end
            end
          end
        end
        if (e.r) have_f = 0;
        if (f_tick === 1'b1) begin
          if (have_f) begin
            tests++;
            if (cyc - last_f != FRAME_CLKS) begin
              fails++;
              $display("FAIL frame_period: got %0d clks, required %0d", cyc - last_f, FRAME_CLKS);
            end
          end
          have_f = 1;
          last_f = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
